// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply-divide controller: op encodings,
// FSM state encoding and default latencies.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    // Ops 0-3 occupy the unit for several cycles; moves complete immediately.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_chk.sv
// Protocol checks for the HI/LO unit, kept apart from the datapath.
module muldiv_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic       busy,
    input logic       op_valid,
    input logic [2:0] op
);

    // The pipeline must hold mult/div/mt instructions out of E while busy.
    a_no_op_while_busy: assert property (
        @(posedge clk) disable iff (!reset)
        !(busy && op_valid && (op <= 3'd5))
    );

endmodule

// File: rtl/muldiv_ctrl_md_alu.sv
// Combinational arithmetic for the HI/LO unit: one shared multiplier and one
// shared unsigned divider, with sign handling wrapped around them.
module md_alu
    import muldiv_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        mul_signed_s;
    logic        div_signed_s;
    logic        rt_zero_s;
    logic [63:0] prod_s;
    logic [31:0] dvd_s;
    logic [31:0] dvs_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Operand conditioning, shared multiply and magnitude divide.
    always_comb begin
        mul_signed_s = (op == MD_MULT);
        div_signed_s = (op == MD_DIV);
        rt_zero_s    = (rt == 32'd0);

        prod_s = {{32{mul_signed_s & rs[31]}}, rs} * {{32{mul_signed_s & rt[31]}}, rt};

        // Signed division runs on magnitudes; 0x80000000 negates to itself,
        // which is its correct unsigned magnitude.
        dvd_s = (div_signed_s && rs[31]) ? (32'd0 - rs) : rs;
        dvs_s = (div_signed_s && rt[31]) ? (32'd0 - rt) : rt;

        if (rt_zero_s) begin
            uquo_s = 32'd0;
            urem_s = 32'd0;
        end else begin
            uquo_s = dvd_s / dvs_s;
            urem_s = dvd_s % dvs_s;
        end

        quo_s = (div_signed_s && (rs[31] ^ rt[31])) ? (32'd0 - uquo_s) : uquo_s;
        rem_s = (div_signed_s && rs[31]) ? (32'd0 - urem_s) : urem_s;
    end

    // Result selection by operation.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                result = prod_s;
            end
            MD_DIV, MD_DIVU: begin
                result      = {rem_s, quo_s};
                div_by_zero = rt_zero_s;
            end
            default: begin
                result      = 64'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide controller: accepts an op from E, holds the unit busy
// for a fixed latency, then commits the precomputed result to HI/LO.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_r;
    md_state_e          state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               busy_r;
    logic               busy_s;
    logic [31:0]        hi_r;
    logic [31:0]        hi_s;
    logic [31:0]        lo_r;
    logic [31:0]        lo_s;
    logic [31:0]        hi_tmp_r;
    logic [31:0]        hi_tmp_s;
    logic [31:0]        lo_tmp_r;
    logic [31:0]        lo_tmp_s;
    logic [63:0]        alu_result_s;
    logic               alu_dbz_s;

    md_alu u_md_alu (
        .op          (op),
        .rs          (rs_data),
        .rt          (rt_data),
        .result      (alu_result_s),
        .div_by_zero (alu_dbz_s)
    );

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        hi_tmp_s = hi_tmp_r;
        lo_tmp_s = lo_tmp_r;
        case (state_r)
            ST_IDLE: begin
                if (op_valid && md_is_arith(op)) begin
                    // A zero divisor stages the current HI/LO so the commit is a no-op.
                    if (alu_dbz_s) begin
                        hi_tmp_s = hi_r;
                        lo_tmp_s = lo_r;
                    end else begin
                        hi_tmp_s = alu_result_s[63:32];
                        lo_tmp_s = alu_result_s[31:0];
                    end
                    cnt_s   = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_s = ST_BUSY;
                    busy_s  = 1'b1;
                end else if (op_valid && (op == MD_MTHI)) begin
                    hi_s = rs_data;
                end else if (op_valid && (op == MD_MTLO)) begin
                    lo_s = rs_data;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_W'(1)) begin
                    hi_s    = hi_tmp_r;
                    lo_s    = lo_tmp_r;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            hi_tmp_r <= 32'd0;
            lo_tmp_r <= 32'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            hi_tmp_r <= hi_tmp_s;
            lo_tmp_r <= lo_tmp_s;
        end
    end

    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = md_use_D && (busy_r || (op_valid && md_is_arith(op)));

    muldiv_ctrl_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy_r),
        .op_valid (op_valid),
        .op       (op)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops
// against an arithmetic reference model using 64-bit integer math.
module tb_muldiv_ctrl;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: {hi, lo} after the op, from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] oh,
                                              input logic [31:0] ol);
        longint          sa, sb, sq, sr, sp;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        res = {oh, ol};
        case (o)
            3'd0: begin sp = sa * sb; res = sp; end
            3'd1: res = ua * ub;
            3'd2: if (b != 32'd0) begin
                      sq = sa / sb;
                      sr = sa % sb;
                      res = {sr[31:0], sq[31:0]};
                  end
            3'd3: if (b != 32'd0) res = {32'(ua % ub), 32'(ua / ub)};
            3'd4: res = {a, ol};
            3'd5: res = {oh, b == b ? a : a};
            default: res = {oh, ol};
        endcase
        return res;
    endfunction

    // Issue one op at the next edge and follow it through its busy window.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        int          n;
        logic [63:0] nxt;
        n   = (o <= 3'd1) ? MULC : ((o <= 3'd3) ? DIVC : 0);
        nxt = ref_model(o, a, b, exp_hi, exp_lo);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b; md_use_D = use_d;
        #1;
        check_val("stall_issue", {63'd0, stall}, {63'd0, use_d && (o <= 3'd3)});
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_val("busy_during", {63'd0, busy}, 64'd1);
            check_val("stall_during", {63'd0, stall}, {63'd0, use_d});
            check_val("hilo_held", {hi, lo}, {exp_hi, exp_lo});
            @(posedge clk); #1;
        end
        exp_hi = nxt[63:32];
        exp_lo = nxt[31:0];
        check_val("busy_done", {63'd0, busy}, 64'd0);
        check_val("stall_done", {63'd0, stall}, 64'd0);
        check_val("hilo_result", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0; op_valid = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        md_use_D = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        #12;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);
        check_val("rst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases, first op at the first edge after reset release.
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check_val("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check_val("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check_val("div_neg7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd4, 32'h1234, 32'd0, 1'b1);
        do_op(3'd5, 32'h5678, 32'd0, 1'b0);
        do_op(3'd3, 32'd99, 32'd0, 1'b1);
        check_val("divu_by0", {hi, lo}, 64'h0000_1234_0000_5678);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd6, 32'hDEAD, 32'hBEEF, 1'b1);
        do_op(3'd2, 32'd5, 32'd0, 1'b0);
        check_val("div_by0", {hi, lo}, 64'h0000_0000_8000_0000);

        // Random ops with occasional zero divisors and extreme operands.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset in the third busy cycle of a DIV aborts without commit.
        op_valid = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd7; md_use_D = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_hilo", {hi, lo}, 64'd0);
        check_val("abort_stall_idle", {63'd0, stall}, 64'd0);
        op_valid = 1'b1; op = 3'd0;
        #1;
        check_val("abort_stall_op", {63'd0, stall}, 64'd1);
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_op(3'd5, 32'hABCD, 32'd0, 1'b0);
        check_val("mtlo_after_rst", {hi, lo}, 64'h0000_0000_0000_ABCD);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_val("hilo_stable", {hi, lo}, {exp_hi, exp_lo});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, meaning the number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op_valid, input, 1 bit: the E-stage instruction is a mult/div/mt operation this cycle.
REQ-006 SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 are ignored.
REQ-007 SHALL have port rs_data, input, 32 bits: forwarded rs operand.
REQ-008 SHALL have port rt_data, input, 32 bits: forwarded rt operand.
REQ-009 SHALL have port md_use_D, input, 1 bit: the D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo.
REQ-010 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 SHALL have port stall, output, 1 bit: freeze the F/D stages and insert a bubble into E.
REQ-012 SHALL have port hi, output, 32 bits: architectural HI.
REQ-013 SHALL have port lo, output, 32 bits: architectural LO.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 IDLE: op_valid with op 0-3 SHALL latch the result into hi_tmp/lo_tmp, load the counter with MUL_CYCLES or DIV_CYCLES, and go to BUSY.
REQ-016 BUSY: the counter SHALL decrement every cycle; at 1 it SHALL commit hi_tmp/lo_tmp to hi/lo and return to IDLE.
REQ-017 Cycle-level timing: an op accepted at edge T SHALL give busy=1 for exactly N cycles, with new hi/lo visible from edge T+N.
REQ-018 MULT SHALL produce the signed 64-bit product, and MULTU the unsigned 64-bit product: hi = [63:32], lo = [31:0].
REQ-019 DIV SHALL produce a signed quotient in lo and remainder in hi, truncating toward zero with the remainder taking the dividend's sign.
REQ-020 DIVU SHALL produce the unsigned quotient in lo and remainder in hi.
REQ-021 DIV/DIVU with rt_data=0 SHALL still run DIV_CYCLES busy cycles and leave hi/lo unchanged.
REQ-022 MTHI/MTLO in IDLE SHALL write rs_data into hi or lo at the next edge, with no busy cycles.
REQ-023 op_valid while BUSY SHALL be ignored, with no state change; this is a pipeline contract violation, flagged by an assertion.
REQ-024 stall SHALL be combinational: md_use_D && (busy || (op_valid && op<=3)).
REQ-025 busy SHALL be 0 in IDLE and 1 in BUSY, registered.
REQ-026 The signed case DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.

Reset
REQ-027 reset low SHALL immediately force the FSM to IDLE, the counter to 0, busy=0, and hi=lo=hi_tmp=lo_tmp=0.
REQ-028 reset asserted mid-operation SHALL abort the operation with no commit; stall SHALL then follow REQ-024 with busy=0.
REQ-029 The first op SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-030 The shared package SHALL hold the op encodings (MD_MULT..MD_MTLO), the FSM state encoding, and the default cycle constants.
REQ-031 A combinational sub-module md_alu SHALL hold the arithmetic (op, rs, rt -> 64-bit result, div_by_zero); muldiv_ctrl SHALL hold the FSM, counter and registers.

Verification
REQ-032 MULT rs=0xFFFFFFFF, rt=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-034 DIV rs=-7, rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU with rt=0 after MTHI 0x1234 and MTLO 0x5678 -> busy for 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
REQ-036 md_use_D=1 throughout a MULT -> stall=1 in the issue cycle and all 5 busy cycles, then 0; md_use_D=0 -> stall=0 throughout.
REQ-037 reset pulsed low at busy cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately, and a MTLO 0xABCD the next cycle gives lo=0xABCD.
